line_window_ctrl: RTL and testbench



---
 rtl/line_window_ctrl_if.sv | 28 ++
 rtl/line_window_ctrl.sv | 76 +++++++
 tb/tb_line_window_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/line_window_ctrl_if.sv
// line_window_ctrl_if: pixel stream, line-FIFO and 3x3 window signals of line_window_ctrl.
interface line_window_ctrl_if #(parameter int COLOR_CHANNEL = 8);
    logic                                i_valid;
    logic [2:0][COLOR_CHANNEL-1:0]       i_pixel;
    logic                                o_ready;
    logic [1:0]                          o_line_write;
    logic [1:0]                          o_line_read;
    logic [2:0][COLOR_CHANNEL-1:0]       o_line0_value;
    logic [2:0][COLOR_CHANNEL-1:0]       o_line1_value;
    logic [2:0][COLOR_CHANNEL-1:0]       i_line0_value;
    logic [2:0][COLOR_CHANNEL-1:0]       i_line1_value;
    logic [1:0]                          i_line_empty;
    logic [1:0]                          i_line_full;
    logic [8:0][2:0][COLOR_CHANNEL-1:0]  o_window;
    logic                                o_valid;
    logic                                o_frame_done;
    logic                                o_error;
    modport slave (
        input  i_valid, i_pixel, i_line0_value, i_line1_value, i_line_empty, i_line_full,
        output o_ready, o_line_write, o_line_read, o_line0_value, o_line1_value,
               o_window, o_valid, o_frame_done, o_error
    );
    modport master (
        output i_valid, i_pixel, i_line0_value, i_line1_value, i_line_empty, i_line_full,
        input  o_ready, o_line_write, o_line_read, o_line0_value, o_line1_value,
               o_window, o_valid, o_frame_done, o_error
    );
endinterface

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: streams raster RGB pixels through two line FIFOs and emits interior 3x3 windows.
module line_window_ctrl #(
    parameter int COLOR_CHANNEL = 8,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480
) (
    input logic               i_clk,
    input logic               i_reset,
    line_window_ctrl_if.slave bus
);
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    typedef enum logic [1:0] {FILL0, FILL1, STREAM, LAST} state_t;
    typedef logic [2:0][COLOR_CHANNEL-1:0] px_t;
    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    px_t [8:0]       win_q, win_d;
    logic            valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic            accept, rd0, rd1, wr0, wr1, x_end, y_end;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= FILL0;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        accept  = bus.i_valid & ~done_q;
        rd0     = state_q != FILL0;
        rd1     = state_q == STREAM || state_q == LAST;
        wr0     = state_q != LAST;
        wr1     = state_q == FILL1 || state_q == STREAM;
        x_end   = x_q == XW'(IMAGE_WIDTH - 1);
        y_end   = y_q == YW'(IMAGE_HEIGHT - 1);
        x_d     = accept ? (x_end ? '0 : x_q + 1'b1) : x_q;
        y_d     = (accept && x_end) ? (y_end ? '0 : y_q + 1'b1) : y_q;
        // Row role follows the row the next pixel belongs to.
        state_d = y_d == '0 ? FILL0 : y_d == YW'(1) ? FILL1 : y_d == YW'(IMAGE_HEIGHT - 1) ? LAST : STREAM;
        win_d   = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]   = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = rd1 ? bus.i_line1_value : '0;
            win_d[5] = rd0 ? bus.i_line0_value : '0;
            win_d[8] = bus.i_pixel;
        end
        valid_d = accept && x_q >= XW'(2) && y_q >= YW'(2);
        done_d  = accept && x_end && y_end;
        err_d   = err_q | (accept & ((rd0 & bus.i_line_empty[0]) | (rd1 & bus.i_line_empty[1]) |
                                     (wr0 & bus.i_line_full[0])  | (wr1 & bus.i_line_full[1])));
    end
    assign bus.o_ready       = ~done_q;
    assign bus.o_line_read   = {accept & rd1, accept & rd0};
    assign bus.o_line_write  = {accept & wr1, accept & wr0};
    assign bus.o_line0_value = bus.i_pixel;
    assign bus.o_line1_value = bus.i_line0_value;
    assign bus.o_window      = win_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_frame_done  = done_q;
    assign bus.o_error       = err_q;
endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl: scoreboard bench for a 4x4 and a 5x3 instance with queue-modelled line FIFOs.
module tb_line_window_ctrl;
    typedef logic [2:0][7:0] px_t;
    typedef logic [8:0][2:0][7:0] win_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_e0 = 1'b0;
    int tests = 0, fails = 0;
    int done_a = 0, done_b = 0, dexp_a = 0, dexp_b = 0;
    win_t qa[$], qb[$];
    px_t f0a[$], f1a[$], f0b[$], f1b[$];
    logic e0a, e1a, e0b, e1b;
    line_window_ctrl_if #(.COLOR_CHANNEL(8)) ba ();
    line_window_ctrl_if #(.COLOR_CHANNEL(8)) bb ();
    line_window_ctrl #(.COLOR_CHANNEL(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut_a (.i_clk(clk), .i_reset(rst), .bus(ba));
    line_window_ctrl #(.COLOR_CHANNEL(8), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(3)) dut_b (.i_clk(clk), .i_reset(rst), .bus(bb));
    always #5 clk = ~clk;
    assign ba.i_line_empty = {e1a, e0a | force_e0};
    assign bb.i_line_empty = {e1b, e0b};
    task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic px_t pix(input int v);
        px_t p;
        p[0] = 8'(v);
        p[1] = 8'(v + 64);
        p[2] = 8'(v + 128);
        return p;
    endfunction
    function automatic win_t exp_win(input int w, input int x, input int y);
        win_t e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                e[r*3+c] = pix((y - 2 + r) * w + x - 2 + c);
        return e;
    endfunction
    // FWFT line FIFO models, depth W+1; strobes beyond empty/full are masked.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f0a.delete();
            f1a.delete();
        end else begin
            if (ba.o_line_read[0] && f0a.size() > 0) void'(f0a.pop_front());
            if (ba.o_line_read[1] && f1a.size() > 0) void'(f1a.pop_front());
            if (ba.o_line_write[0] && f0a.size() < 5) f0a.push_back(ba.o_line0_value);
            if (ba.o_line_write[1] && f1a.size() < 5) f1a.push_back(ba.o_line1_value);
        end
        e0a <= f0a.size() == 0;
        e1a <= f1a.size() == 0;
        ba.i_line_full <= {f1a.size() >= 5, f0a.size() >= 5};
        ba.i_line0_value <= f0a.size() > 0 ? f0a[0] : '0;
        ba.i_line1_value <= f1a.size() > 0 ? f1a[0] : '0;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f0b.delete();
            f1b.delete();
        end else begin
            if (bb.o_line_read[0] && f0b.size() > 0) void'(f0b.pop_front());
            if (bb.o_line_read[1] && f1b.size() > 0) void'(f1b.pop_front());
            if (bb.o_line_write[0] && f0b.size() < 6) f0b.push_back(bb.o_line0_value);
            if (bb.o_line_write[1] && f1b.size() < 6) f1b.push_back(bb.o_line1_value);
        end
        e0b <= f0b.size() == 0;
        e1b <= f1b.size() == 0;
        bb.i_line_full <= {f1b.size() >= 6, f0b.size() >= 6};
        bb.i_line0_value <= f0b.size() > 0 ? f0b[0] : '0;
        bb.i_line1_value <= f1b.size() > 0 ? f1b[0] : '0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (ba.o_valid) begin
                if (qa.size() == 0) check("extra_valid_a", ba.o_valid, 1'b0);
                else check("win_a", ba.o_window, qa.pop_front());
            end
            if (bb.o_valid) begin
                if (qb.size() == 0) check("extra_valid_b", bb.o_valid, 1'b0);
                else check("win_b", bb.o_window, qb.pop_front());
            end
            if (ba.o_frame_done) begin
                done_a++;
                check("ready_at_done_a", ba.o_ready, 1'b0);
            end
            if (bb.o_frame_done) begin
                done_b++;
                check("ready_at_done_b", bb.o_ready, 1'b0);
            end
        end
    end
    task automatic send(input bit s, input int x, input int y, input bit gap);
        int n = 0;
        if (s) begin
            bb.i_valid = 1'b1;
            bb.i_pixel = pix(y * 5 + x);
        end else begin
            ba.i_valid = 1'b1;
            ba.i_pixel = pix(y * 4 + x);
        end
        while (!(s ? bb.o_ready : ba.o_ready) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 8) check("ready_timeout", 1'b0, 1'b1);
        if (x >= 2 && y >= 2) begin
            if (s) qb.push_back(exp_win(5, x, y));
            else qa.push_back(exp_win(4, x, y));
        end
        @(posedge clk); #1;
        ba.i_valid = 1'b0;
        bb.i_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask
    task automatic frame(input bit s, input bit gap, input int frow);
        int w = s ? 5 : 4;
        int h = s ? 3 : 4;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (!s) force_e0 = (y == frow);
                send(s, x, y, gap);
            end
        force_e0 = 1'b0;
        check(s ? "empty_b" : "empty_a", s ? bb.i_line_empty : ba.i_line_empty, 2'b11);
        if (s) dexp_b++;
        else dexp_a++;
        @(negedge clk); #1;
        check(s ? "pending_b" : "pending_a", s ? qb.size() : qa.size(), 0);
        check(s ? "frame_done_b" : "frame_done_a", s ? done_b : done_a, s ? dexp_b : dexp_a);
        check(s ? "error_b" : "error_a", s ? bb.o_error : ba.o_error, frow >= 0);
    endtask
    task automatic check_reset_a();
        check("rst_valid", ba.o_valid, 1'b0);
        check("rst_window", ba.o_window, '0);
        check("rst_done", ba.o_frame_done, 1'b0);
        check("rst_error", ba.o_error, 1'b0);
        check("rst_ready", ba.o_ready, 1'b1);
    endtask
    initial begin
        ba.i_valid = 1'b0;
        ba.i_pixel = '0;
        bb.i_valid = 1'b0;
        bb.i_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a();
        check("rst_valid_b", bb.o_valid, 1'b0);
        rst = 1'b0;
        frame(0, 0, -1);
        frame(0, 1, -1);
        frame(0, 0, -1);
        frame(0, 0, -1);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4 && !(y == 2 && x > 1); x++)
                send(0, x, y, 0);
        check("win_before_reset", ba.o_window != '0, 1'b1);
        #3 rst = 1'b1;
        #1 check_reset_a();
        qa.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        frame(0, 0, -1);
        frame(0, 0, 1);
        check("error_sticky", ba.o_error, 1'b1);
        #3 rst = 1'b1;
        #1 check("error_cleared", ba.o_error, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        frame(0, 0, -1);
        frame(1, 0, -1);
        frame(1, 1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
